// File: rtl/mem_mmio_bus_pkg.sv
// Shared address-map definitions for the memory/IO stage: region codes, read-select
// encoding and the address decoder used by the top.
package mem_map_pkg;

  localparam logic [3:0] REG_RAM = 4'h0;
  localparam logic [3:0] REG_LED = 4'h1;
  localparam logic [3:0] REG_TMR = 4'h2;
  localparam logic [3:0] REG_SW  = 4'h3;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_TMR,
    SEL_SW
  } rd_sel_t;

  // RAM only claims addresses whose bits above the RAM word index are all zero.
  function automatic rd_sel_t decode(input logic [31:0] addr, input int unsigned ram_aw);
    rd_sel_t sel;
    case (addr[31:28])
      REG_RAM: sel = ((addr[27:0] >> ram_aw) == 28'd0) ? SEL_RAM : SEL_NONE;
      REG_LED: sel = SEL_LED;
      REG_TMR: sel = SEL_TMR;
      REG_SW:  sel = SEL_SW;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_mmio_bus_if.sv
// Core-side word bus: address, write data and strobe from the core, read data back.
interface mem_mmio_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        W;
  logic [31:0] din;

  modport master (output addr, output wdata, output W, input din);
  modport slave  (input addr, input wdata, input W, output din);
endinterface

// File: rtl/mem_mmio_bus_sync_ram.sv
// Single-port 32-bit RAM with registered, read-first output.
module sync_ram #(
  parameter int unsigned AW = 8,
  parameter INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);

  logic [31:0] mem [2**AW];

  // Read and write on the same edge: q takes the word held before this write.
  always_ff @(posedge clk) begin
    if (en) begin
      q <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/mem_mmio_bus.sv
// Memory/IO stage: decodes the core bus onto RAM, LED register, switch port and cycle
// timer, returning read data with a fixed one-cycle latency.
module mem_mmio_bus
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_AW = 8,
  parameter int unsigned LED_W  = 10,
  parameter int unsigned SW_W   = 10,
  parameter INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             resetn,
  mem_mmio_bus_if.slave    bus,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic             bus_err
);

  rd_sel_t           sel;
  rd_sel_t           rd_sel;
  logic [31:0]       ram_q;
  logic [31:0]       snap;
  logic [31:0]       timer;
  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;

  assign sel = decode(bus.addr, RAM_AW);

  sync_ram #(
    .AW        (RAM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (sel == SEL_RAM),
    .we    (bus.W),
    .addr  (bus.addr[RAM_AW-1:0]),
    .wdata (bus.wdata),
    .q     (ram_q)
  );

  // Peripheral snapshots capture the value before this edge's own update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_sel <= SEL_NONE;
      snap   <= '0;
    end else begin
      rd_sel <= sel;
      case (sel)
        SEL_LED: snap <= 32'(led);
        SEL_TMR: snap <= timer;
        SEL_SW:  snap <= 32'(sw_sync);
        default: snap <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led     <= '0;
      timer   <= '0;
      bus_err <= 1'b0;
    end else begin
      if (bus.W && sel == SEL_LED) led <= bus.wdata[LED_W-1:0];
      timer <= (bus.W && sel == SEL_TMR) ? bus.wdata : timer + 32'd1;
      if (sel == SEL_NONE) bus_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  always_comb begin
    bus.din = '0;
    case (rd_sel)
      SEL_RAM:  bus.din = ram_q;
      SEL_NONE: bus.din = '0;
      default:  bus.din = snap;
    endcase
  end

endmodule

// File: tb/tb_mem_mmio_bus.sv
// Directed bench for mem_mmio_bus: hand-computed expectations checked one cycle after each access.
module tb_mem_mmio_bus;

  logic        clk;
  logic        resetn;
  logic [9:0]  sw;
  logic [9:0]  led;
  logic        bus_err;
  int unsigned n_cmp;
  int unsigned n_err;

  mem_mmio_bus_if bus ();

  mem_mmio_bus #(
    .RAM_AW    (8),
    .LED_W     (10),
    .SW_W      (10),
    .INIT_FILE ("")
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .sw      (sw),
    .led     (led),
    .bus_err (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic [31:0] a, input logic w, input logic [31:0] d);
    bus.addr  = a;
    bus.W     = w;
    bus.wdata = d;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    resetn = 1'b0;
    sw     = '0;
    acc(32'h0, 1'b0, 32'h0);
    repeat (3) tick();
    chk("rst_din", bus.din, 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_err", 32'(bus_err), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // RAM write then read
    acc(32'h0000_0005, 1'b1, 32'hDEAD_BEEF); tick();
    acc(32'h0000_0005, 1'b0, 32'h0);         tick();
    chk("ram_rd", bus.din, 32'hDEAD_BEEF);
    chk("ram_err", 32'(bus_err), 32'h0);

    // read-first on same-address write+read
    acc(32'h0000_0007, 1'b1, 32'h11); tick();
    acc(32'h0000_0007, 1'b1, 32'h22); tick();
    chk("rdw_old", bus.din, 32'h11);
    acc(32'h0000_0007, 1'b0, 32'h0);  tick();
    chk("rdw_new", bus.din, 32'h22);

    // LED: upper wdata bits dropped, read on the write edge returns pre-write value
    acc(32'h1000_0000, 1'b1, 32'hFFFF_F3FF); tick();
    chk("led_out", 32'(led), 32'h3FF);
    chk("led_prewr", bus.din, 32'h0);
    acc(32'h1ABC_0000, 1'b0, 32'h0); tick();
    chk("led_rd", bus.din, 32'h0000_03FF);

    // Timer wrap
    acc(32'h2000_0000, 1'b1, 32'hFFFF_FFFE); tick();
    acc(32'h0000_0000, 1'b0, 32'h0); tick(); tick();
    acc(32'h2000_0000, 1'b0, 32'h0); tick();
    chk("tmr_wrap", bus.din, 32'h0);
    tick();
    chk("tmr_inc", bus.din, 32'h1);
    acc(32'h2000_0000, 1'b1, 32'h100); tick();
    acc(32'h2000_0000, 1'b0, 32'h0);   tick();
    chk("tmr_load", bus.din, 32'h100);
    tick();
    chk("tmr_resume", bus.din, 32'h101);

    // Switch synchronizer latency
    sw = 10'h2A5;
    acc(32'h3000_0000, 1'b0, 32'h0); tick();
    chk("sw_old", bus.din, 32'h0);
    tick();
    chk("sw_mid", bus.din, 32'h0);
    tick();
    chk("sw_new", bus.din, 32'h0000_02A5);

    // Unmapped region
    acc(32'h0000_0000, 1'b1, 32'h1234); tick();
    acc(32'h5000_0000, 1'b0, 32'h0);    tick();
    chk("unm_err", 32'(bus_err), 32'h1);
    chk("unm_din", bus.din, 32'h0);

    // Reset while an LED read is pending
    acc(32'h1000_0000, 1'b0, 32'h0); tick();
    chk("pre_rst_led", bus.din, 32'h3FF);
    resetn = 1'b0;
    #1;
    chk("mid_rst_din", bus.din, 32'h0);
    chk("mid_rst_led", 32'(led), 32'h0);
    chk("mid_rst_err", 32'(bus_err), 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Out-of-range RAM write must not alias word 0
    acc(32'h0000_0100, 1'b1, 32'h0000_0BAD); tick();
    chk("oor_err", 32'(bus_err), 32'h1);
    chk("oor_din", bus.din, 32'h0);
    acc(32'h0000_0000, 1'b0, 32'h0); tick();
    chk("oor_ram0", bus.din, 32'h1234);
    acc(32'h0000_0005, 1'b0, 32'h0); tick();
    chk("ram_keep", bus.din, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
